id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
Decode-to-execute pipeline stage of the RV32I core, directly upstream of the ALU.
- Registers decoded operands and control with a valid/ready handshake.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and stalls on load-use.
- Drives the ALU's in1, in2 and ALUCtrl inputs.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register address width

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of held instruction (branch/jump redirect)
dec_valid  input  1  decode payload valid
dec_ready  output  1  stage can accept payload
dec_pc  input  XLEN  instruction PC
dec_rs1_data, dec_rs2_data  input  XLEN each  register-file read data
dec_imm  input  XLEN  sign-extended immediate
dec_rs1_addr, dec_rs2_addr, dec_rd_addr  input  REG_AW each  register indices
dec_alu_ctrl  input  4  ALU opcode (package encoding)
dec_src1_sel  input  1  0=rs1, 1=pc
dec_src2_sel  input  1  0=rs2, 1=imm
dec_reg_write  input  1  instruction writes rd
exm_reg_write, exm_is_load  input  1 each  EX/MEM producer info
exm_rd  input  REG_AW  EX/MEM destination
exm_result  input  XLEN  EX/MEM ALU result
mwb_reg_write  input  1  MEM/WB writes rd
mwb_rd  input  REG_AW  MEM/WB destination
mwb_result  input  XLEN  MEM/WB writeback value
ex_valid  output  1  operands valid for execute
ex_ready  input  1  execute/downstream accepts
alu_in1, alu_in2  output  XLEN each  ALU operands
alu_ctrl  output  4  ALU opcode
ex_rs2_val  output  XLEN  forwarded rs2 (store data)
ex_pc  output  XLEN  held PC
ex_rd  output  REG_AW  held rd
ex_reg_write  output  1  held write enable

Behaviour:
- Reset (async, rst_n=0): valid_q=0; all payload registers 0. Resulting outputs: ex_valid=0, alu_in1=alu_in2=0, alu_ctrl=0000 (ADD), ex_rd=0, ex_reg_write=0. Release takes effect on the next clk edge.
- Handshake:
  - dec_ready = !valid_q || (ex_valid && ex_ready).
  - Capture on dec_valid && dec_ready; one-cycle latency, payload visible the cycle after capture.
  - Back-to-back throughput is 1/cycle.
- ex_valid = valid_q && !hazard.
  - Instruction retires when ex_valid && ex_ready.
  - Retire without new capture clears valid_q.
- Forwarding, applied combinationally per operand to held rsN data:
  - Match requires exm/mwb_reg_write=1, rd == rsN_addr, and rd != 0.
  - EX/MEM has priority over MEM/WB; otherwise the held register value is used.
  - rs1/rs2 are never forwarded for x0.
- Load-use hazard: hazard=1 when an EX/MEM match on a used source has exm_is_load=1.
  - A source counts as used: rs1 when src1_sel=0; rs2 always (store data).
  - While hazard: ex_valid=0, dec_ready=0, payload held.
- Refresh while held: each cycle valid_q=1 and not retiring, held rs1/rs2 data registers load their forwarded value. The operand is then preserved after the producer leaves MEM/WB.
- Operand select:
  - alu_in1 = src1_sel ? pc : fwd_rs1.
  - alu_in2 = src2_sel ? imm : fwd_rs2.
  - ex_rs2_val = fwd_rs2.
- Flush:
  - Next edge valid_q=0; flush overrides simultaneous capture and refresh.
  - dec_ready is still computed normally. An accepted payload in the flush cycle is discarded.
- Outputs are held stable while ex_valid && !ex_ready.
- Reset mid-operation drops the held instruction immediately, with no retire.

Optional Feature:
ID_EX_FORWARD_EN
- Defined: forwarding, refresh and load-use-only stall as above.
- Undefined: no forwarding paths.
  - hazard=1 whenever any used source matches exm_rd or mwb_rd (reg_write=1, rd != 0), regardless of exm_is_load.
  - Operands come from the held register data only. Refresh is still done from mwb_result, so the stall can clear.

Decomposition:
- Package riscv_pkg:
  - ALU opcode localparams: ADD=0000, SUB=1000, XOR=0100, OR=0110, AND=0111, SLL=0001, SRL=0101, SRA=1101, SLT=0010, SLTU=0011.
  - src1/src2 select enums.
  - Packed struct id_ex_payload_t.
- Sub-module fwd_mux: per-operand match/priority logic returning value plus load-hazard flag; instantiated twice.

Test Plan:
- Reset asserted mid-stream with valid_q=1 -> ex_valid=0, alu_in1=0, alu_ctrl=0000 immediately; after release, first capture appears exactly 1 cycle later.
- Capture ADD, rs1=x5 (0x10), rs2=x6 (0x20), exm_rd=5, exm_result=0x99, mwb_rd=5, mwb_result=0x77 -> alu_in1=0x99 (EX/MEM priority), alu_in2=0x20.
- exm_rd=0, exm_reg_write=1, exm_result=0xDEAD, rs1=x0 data 0 -> alu_in1=0 (no x0 forwarding).
- Held instruction with rs2=x7, exm_is_load=1, exm_rd=7 -> ex_valid=0, dec_ready=0. Next cycle mwb_rd=7, mwb_result=0x1234 -> ex_valid=1, alu_in2=0x1234. Value stays 0x1234 after MEM/WB changes, while ex_ready=0.
- ex_ready=0 for 3 cycles with dec_valid=1 -> outputs stable, dec_ready=0, no payload overwrite; ex_ready=1 -> retire and capture in same edge.
- flush=1 with dec_valid=1, dec_ready=1 -> ex_valid=0 next cycle; the accepted payload never appears on the outputs.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I types for the ID/EX slice: ALU opcodes, operand-select enums and the held payload.
package riscv_pkg;

  localparam int RV_XLEN   = 32;
  localparam int RV_REG_AW = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;

  typedef enum logic {SRC1_RS1 = 1'b0, SRC1_PC  = 1'b1} src1_sel_e;
  typedef enum logic {SRC2_RS2 = 1'b0, SRC2_IMM = 1'b1} src2_sel_e;

  typedef struct packed {
    logic [RV_XLEN-1:0]   pc;
    logic [RV_XLEN-1:0]   rs1_data;
    logic [RV_XLEN-1:0]   rs2_data;
    logic [RV_XLEN-1:0]   imm;
    logic [RV_REG_AW-1:0] rs1_addr;
    logic [RV_REG_AW-1:0] rs2_addr;
    logic [RV_REG_AW-1:0] rd_addr;
    logic [3:0]           alu_ctrl;
    src1_sel_e            src1_sel;
    src2_sel_e            src2_sel;
    logic                 reg_write;
  } id_ex_payload_t;

endpackage

// File: rtl/fwd_mux.sv
// Per-operand bypass: EX/MEM beats MEM/WB, x0 never matches; combinational, no storage.
// ID_EX_FORWARD_EN selects real forwarding; otherwise any pending producer raises the hazard.
module fwd_mux #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rs_addr,
  input  logic [XLEN-1:0]   i_rs_data,
  input  logic              i_used,
  input  logic              i_exm_reg_write,
  input  logic              i_exm_is_load,
  input  logic [REG_AW-1:0] i_exm_rd,
  input  logic [XLEN-1:0]   i_exm_result,
  input  logic              i_mwb_reg_write,
  input  logic [REG_AW-1:0] i_mwb_rd,
  input  logic [XLEN-1:0]   i_mwb_result,
  output logic [XLEN-1:0]   o_val,
  output logic [XLEN-1:0]   o_refresh,
  output logic              o_hazard
);

  logic w_exm_hit;
  logic w_mwb_hit;

  assign w_exm_hit = i_exm_reg_write && (i_exm_rd == i_rs_addr) && (i_exm_rd != '0);
  assign w_mwb_hit = i_mwb_reg_write && (i_mwb_rd == i_rs_addr) && (i_mwb_rd != '0);

`ifdef ID_EX_FORWARD_EN
  always_comb begin
    o_val = i_rs_data;
    if (w_exm_hit) begin
      o_val = i_exm_result;
    end else if (w_mwb_hit) begin
      o_val = i_mwb_result;
    end
  end

  assign o_refresh = o_val;
  // Only a load in EX/MEM is too late to bypass; ALU results are forwarded.
  assign o_hazard  = i_used && w_exm_hit && i_exm_is_load;
`else
  logic w_unused_exm;

  assign w_unused_exm = ^{i_exm_is_load, i_exm_result};
  assign o_val        = i_rs_data;
  // Soak up the writeback value while stalled so the hazard can drain.
  assign o_refresh    = w_mwb_hit ? i_mwb_result : i_rs_data;
  assign o_hazard     = i_used && (w_exm_hit || w_mwb_hit);
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register feeding the ALU: 1-cycle capture latency, valid/ready, stalls on unresolved RAW.
// Build option ID_EX_FORWARD_EN enables EX/MEM and MEM/WB bypass (load-use-only stall).
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = RV_XLEN,
  parameter int REG_AW = RV_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [XLEN-1:0]   dec_pc,
  input  logic [XLEN-1:0]   dec_rs1_data,
  input  logic [XLEN-1:0]   dec_rs2_data,
  input  logic [XLEN-1:0]   dec_imm,
  input  logic [REG_AW-1:0] dec_rs1_addr,
  input  logic [REG_AW-1:0] dec_rs2_addr,
  input  logic [REG_AW-1:0] dec_rd_addr,
  input  logic [3:0]        dec_alu_ctrl,
  input  logic              dec_src1_sel,
  input  logic              dec_src2_sel,
  input  logic              dec_reg_write,
  input  logic              exm_reg_write,
  input  logic              exm_is_load,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_result,
  input  logic              mwb_reg_write,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [XLEN-1:0]   mwb_result,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   alu_in1,
  output logic [XLEN-1:0]   alu_in2,
  output logic [3:0]        alu_ctrl,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [XLEN-1:0]   ex_pc,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write
);

  logic           r_valid;
  id_ex_payload_t r_pay;

  logic [XLEN-1:0] w_fwd1;
  logic [XLEN-1:0] w_fwd2;
  logic [XLEN-1:0] w_refresh1;
  logic [XLEN-1:0] w_refresh2;
  logic            w_hz1;
  logic            w_hz2;
  logic            w_used1;
  logic            w_capture;
  logic            w_retire;

  assign w_used1 = (r_pay.src1_sel == SRC1_RS1);

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .i_rs_addr       (r_pay.rs1_addr),
    .i_rs_data       (r_pay.rs1_data),
    .i_used          (w_used1),
    .i_exm_reg_write (exm_reg_write),
    .i_exm_is_load   (exm_is_load),
    .i_exm_rd        (exm_rd),
    .i_exm_result    (exm_result),
    .i_mwb_reg_write (mwb_reg_write),
    .i_mwb_rd        (mwb_rd),
    .i_mwb_result    (mwb_result),
    .o_val           (w_fwd1),
    .o_refresh       (w_refresh1),
    .o_hazard        (w_hz1)
  );

  // rs2 always counts as used: stores need it even when the ALU takes the immediate.
  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .i_rs_addr       (r_pay.rs2_addr),
    .i_rs_data       (r_pay.rs2_data),
    .i_used          (1'b1),
    .i_exm_reg_write (exm_reg_write),
    .i_exm_is_load   (exm_is_load),
    .i_exm_rd        (exm_rd),
    .i_exm_result    (exm_result),
    .i_mwb_reg_write (mwb_reg_write),
    .i_mwb_rd        (mwb_rd),
    .i_mwb_result    (mwb_result),
    .o_val           (w_fwd2),
    .o_refresh       (w_refresh2),
    .o_hazard        (w_hz2)
  );

  assign ex_valid  = r_valid && !(w_hz1 || w_hz2);
  assign dec_ready = !r_valid || (ex_valid && ex_ready);
  assign w_capture = dec_valid && dec_ready;
  assign w_retire  = ex_valid && ex_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pay   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid            <= 1'b1;
      r_pay.pc           <= dec_pc;
      r_pay.rs1_data     <= dec_rs1_data;
      r_pay.rs2_data     <= dec_rs2_data;
      r_pay.imm          <= dec_imm;
      r_pay.rs1_addr     <= dec_rs1_addr;
      r_pay.rs2_addr     <= dec_rs2_addr;
      r_pay.rd_addr      <= dec_rd_addr;
      r_pay.alu_ctrl     <= dec_alu_ctrl;
      r_pay.src1_sel     <= src1_sel_e'(dec_src1_sel);
      r_pay.src2_sel     <= src2_sel_e'(dec_src2_sel);
      r_pay.reg_write    <= dec_reg_write;
    end else if (w_retire) begin
      r_valid <= 1'b0;
    end else if (r_valid) begin
      // Latch bypassed values so the operand survives once the producer retires.
      r_pay.rs1_data <= w_refresh1;
      r_pay.rs2_data <= w_refresh2;
    end
  end

  assign alu_in1      = (r_pay.src1_sel == SRC1_PC)  ? r_pay.pc  : w_fwd1;
  assign alu_in2      = (r_pay.src2_sel == SRC2_IMM) ? r_pay.imm : w_fwd2;
  assign alu_ctrl     = r_pay.alu_ctrl;
  assign ex_rs2_val   = w_fwd2;
  assign ex_pc        = r_pay.pc;
  assign ex_rd        = r_pay.rd_addr;
  assign ex_reg_write = r_pay.reg_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus a random burst, checked against a rule-level model.
module tb_id_ex_stage;
  import riscv_pkg::*;

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush, dec_valid, dec_ready;
  logic [31:0] dec_pc, dec_rs1_data, dec_rs2_data, dec_imm;
  logic [4:0]  dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
  logic [3:0]  dec_alu_ctrl;
  logic        dec_src1_sel, dec_src2_sel, dec_reg_write;
  logic        exm_reg_write, exm_is_load, mwb_reg_write;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_result, mwb_result;
  logic        ex_valid, ex_ready, ex_reg_write;
  logic [31:0] alu_in1, alu_in2, ex_rs2_val, ex_pc;
  logic [3:0]  alu_ctrl;
  logic [4:0]  ex_rd;

  int checks = 0;
  int errors = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
    .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data), .dec_imm(dec_imm),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr), .dec_rd_addr(dec_rd_addr),
    .dec_alu_ctrl(dec_alu_ctrl), .dec_src1_sel(dec_src1_sel), .dec_src2_sel(dec_src2_sel),
    .dec_reg_write(dec_reg_write),
    .exm_reg_write(exm_reg_write), .exm_is_load(exm_is_load), .exm_rd(exm_rd),
    .exm_result(exm_result), .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd),
    .mwb_result(mwb_result), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl), .ex_rs2_val(ex_rs2_val),
    .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sel(input logic [31:0] f, input logic [31:0] n);
    return FWD ? f : n;
  endfunction

  // ---------------- reference model ----------------
  logic        m_valid, m_s1, m_s2, m_rw;
  logic [31:0] m_pc, m_r1, m_r2, m_imm;
  logic [4:0]  m_a1, m_a2, m_rd;
  logic [3:0]  m_ctrl;

  function automatic logic hit(input logic we, input logic [4:0] rd, input logic [4:0] a);
    return we && (rd == a) && (rd != 5'd0);
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] a, input logic [31:0] held);
    if (FWD && hit(exm_reg_write, exm_rd, a)) return exm_result;
    if (FWD && hit(mwb_reg_write, mwb_rd, a)) return mwb_result;
    return held;
  endfunction

  function automatic logic [31:0] refr(input logic [4:0] a, input logic [31:0] held);
    if (FWD) return opnd(a, held);
    return hit(mwb_reg_write, mwb_rd, a) ? mwb_result : held;
  endfunction

  function automatic logic pending(input logic [4:0] a);
    if (FWD) return hit(exm_reg_write, exm_rd, a) && exm_is_load;
    return hit(exm_reg_write, exm_rd, a) || hit(mwb_reg_write, mwb_rd, a);
  endfunction

  function automatic logic m_exv();
    return m_valid && !((!m_s1 && pending(m_a1)) || pending(m_a2));
  endfunction

  function automatic logic m_decr();
    return !m_valid || (m_exv() && ex_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 0; m_pc <= 0; m_r1 <= 0; m_r2 <= 0; m_imm <= 0;
      m_a1 <= 0; m_a2 <= 0; m_rd <= 0; m_ctrl <= 0; m_s1 <= 0; m_s2 <= 0; m_rw <= 0;
    end else if (flush) begin
      m_valid <= 0;
    end else if (dec_valid && m_decr()) begin
      m_valid <= 1; m_pc <= dec_pc; m_r1 <= dec_rs1_data; m_r2 <= dec_rs2_data;
      m_imm <= dec_imm; m_a1 <= dec_rs1_addr; m_a2 <= dec_rs2_addr; m_rd <= dec_rd_addr;
      m_ctrl <= dec_alu_ctrl; m_s1 <= dec_src1_sel; m_s2 <= dec_src2_sel; m_rw <= dec_reg_write;
    end else if (m_exv() && ex_ready) begin
      m_valid <= 0;
    end else if (m_valid) begin
      m_r1 <= refr(m_a1, m_r1);
      m_r2 <= refr(m_a2, m_r2);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst ex_valid", ex_valid, 0);
      chk("rst alu_in1", alu_in1, 0);
      chk("rst alu_in2", alu_in2, 0);
      chk("rst alu_ctrl", alu_ctrl, ALU_ADD);
      chk("rst ex_rd", ex_rd, 0);
      chk("rst ex_reg_write", ex_reg_write, 0);
    end else begin
      chk("mdl ex_valid", ex_valid, m_exv());
      chk("mdl dec_ready", dec_ready, m_decr());
      if (m_exv()) begin
        chk("mdl alu_in1", alu_in1, m_s1 ? m_pc : opnd(m_a1, m_r1));
        chk("mdl alu_in2", alu_in2, m_s2 ? m_imm : opnd(m_a2, m_r2));
        chk("mdl alu_ctrl", alu_ctrl, m_ctrl);
        chk("mdl ex_rs2_val", ex_rs2_val, opnd(m_a2, m_r2));
        chk("mdl ex_pc", ex_pc, m_pc);
        chk("mdl ex_rd", ex_rd, m_rd);
        chk("mdl ex_reg_write", ex_reg_write, m_rw);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [4:0] a1, input logic [31:0] d1,
                      input logic [4:0] a2, input logic [31:0] d2, input logic [31:0] imm,
                      input logic [4:0] rd, input logic [3:0] ctrl, input logic s1, input logic s2);
    dec_valid = 1; dec_pc = pc; dec_rs1_addr = a1; dec_rs1_data = d1;
    dec_rs2_addr = a2; dec_rs2_data = d2; dec_imm = imm; dec_rd_addr = rd;
    dec_alu_ctrl = ctrl; dec_src1_sel = s1; dec_src2_sel = s2; dec_reg_write = 1;
  endtask

  task automatic bypass(input logic ew, input logic el, input logic [4:0] erd, input logic [31:0] eres,
                        input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
    exm_reg_write = ew; exm_is_load = el; exm_rd = erd; exm_result = eres;
    mwb_reg_write = mw; mwb_rd = mrd; mwb_result = mres;
  endtask

  initial begin
    flush = 0; dec_valid = 0; ex_ready = 0;
    send(0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0);
    dec_valid = 0; dec_reg_write = 0;
    bypass(0, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    chk("reset dec_ready", dec_ready, 1);
    tick();
    rst_n = 1;

    // EX/MEM wins over MEM/WB for rs1
    send(32'h100, 5'd5, 32'h10, 5'd6, 32'h20, 32'h0, 5'd1, ALU_ADD, 0, 0);
    tick();
    dec_valid = 0; ex_ready = 1;
    bypass(1, 0, 5'd5, 32'h99, 1, 5'd5, 32'h77);
    @(negedge clk);
    chk("prio ex_valid", ex_valid, sel(1, 0));
    chk("prio alu_in1", alu_in1, sel(32'h99, 32'h10));
    chk("prio alu_in2", alu_in2, 32'h20);
    tick();
    bypass(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("drain ex_valid", ex_valid, sel(0, 1));
    chk("drain alu_in1", alu_in1, sel(32'h10, 32'h77));
    tick();

    // x0 is never forwarded
    send(32'h200, 5'd0, 32'h0, 5'd3, 32'h33, 32'h5, 5'd2, ALU_ADD, 0, 1);
    bypass(1, 0, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF);
    tick();
    dec_valid = 0;
    @(negedge clk);
    chk("x0 ex_valid", ex_valid, 1);
    chk("x0 alu_in1", alu_in1, 0);
    chk("x0 alu_in2", alu_in2, 5);
    chk("x0 rs2_val", ex_rs2_val, 32'h33);
    tick();
    bypass(0, 0, 0, 0, 0, 0, 0);

    // load-use on rs2, then hold under backpressure
    send(32'h300, 5'd1, 32'h11, 5'd7, 32'h70, 32'h0, 5'd9, ALU_ADD, 0, 0);
    tick();
    send(32'h400, 5'd2, 32'h40, 5'd3, 32'h4, 32'h10, 5'd4, ALU_SUB, 1, 1);
    bypass(1, 1, 5'd7, 32'hAAAA, 0, 0, 0);
    @(negedge clk);
    chk("lu ex_valid", ex_valid, 0);
    chk("lu dec_ready", dec_ready, 0);
    tick();
    ex_ready = 0;
    bypass(0, 0, 0, 0, 1, 5'd7, 32'h1234);
    @(negedge clk);
    chk("lu wb ex_valid", ex_valid, sel(1, 0));
    chk("lu wb alu_in2", alu_in2, sel(32'h1234, 32'h70));
    tick();
    mwb_rd = 5'd12; mwb_result = 32'h5555;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold ex_valid", ex_valid, 1);
      chk("hold alu_in2", alu_in2, 32'h1234);
      chk("hold ex_pc", ex_pc, 32'h300);
      chk("hold dec_ready", dec_ready, 0);
      tick();
    end
    ex_ready = 1; mwb_reg_write = 0;
    @(negedge clk);
    chk("swap dec_ready", dec_ready, 1);
    tick();
    dec_valid = 0; ex_ready = 0;
    @(negedge clk);
    chk("swap ex_pc", ex_pc, 32'h400);
    chk("swap alu_in1", alu_in1, 32'h400);
    chk("swap alu_ctrl", alu_ctrl, ALU_SUB);
    tick();

    // flush discards the payload accepted in the same cycle
    flush = 1; ex_ready = 1;
    send(32'h500, 5'd1, 32'h1, 5'd2, 32'h2, 32'h3, 5'd5, ALU_OR, 0, 0);
    @(negedge clk);
    chk("flush dec_ready", dec_ready, 1);
    tick();
    flush = 0; dec_valid = 0;
    @(negedge clk);
    chk("flush ex_valid", ex_valid, 0);
    tick();
    @(negedge clk);
    chk("flush later ex_valid", ex_valid, 0);
    tick();

    // reset with an instruction held
    send(32'h600, 5'd1, 32'h1, 5'd2, 32'h2, 32'h3, 5'd6, ALU_XOR, 1, 0);
    tick();
    dec_valid = 0; ex_ready = 0;
    @(negedge clk);
    chk("pre-rst ex_pc", ex_pc, 32'h600);
    #2;
    rst_n = 0;
    #1;
    chk("async ex_valid", ex_valid, 0);
    chk("async alu_in1", alu_in1, 0);
    chk("async alu_ctrl", alu_ctrl, ALU_ADD);
    tick();
    rst_n = 1; ex_ready = 1;
    send(32'h700, 5'd1, 32'h1, 5'd2, 32'h2, 32'h3, 5'd7, ALU_AND, 0, 1);
    @(negedge clk);
    chk("post-rst ex_valid", ex_valid, 0);
    tick();
    send(32'h800, 5'd3, 32'h3, 5'd4, 32'h4, 32'h5, 5'd8, ALU_SLT, 0, 0);
    @(negedge clk);
    chk("b2b first ex_pc", ex_pc, 32'h700);
    chk("b2b dec_ready", dec_ready, 1);
    tick();
    dec_valid = 0;
    @(negedge clk);
    chk("b2b second ex_valid", ex_valid, 1);
    chk("b2b second ex_pc", ex_pc, 32'h800);
    tick();

    // random burst with live bypass traffic
    for (int n = 0; n < 60; n++) begin
      send($urandom, 5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), $urandom,
           $urandom, 5'($urandom_range(0, 7)), 4'($urandom), 1'($urandom), 1'($urandom));
      dec_valid = ($urandom_range(0, 3) != 0);
      ex_ready  = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      bypass(1'($urandom), ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)), $urandom,
             1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      tick();
    end
    dec_valid = 0; flush = 0; ex_ready = 1;
    bypass(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
